fpga_cfg_loader: RTL and testbench

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_pkg.sv | 42 ++++
 rtl/cfg_fifo.sv | 57 +++++
 rtl/fpga_cfg_loader.sv | 178 +++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
// Covers the FSM states, the register word indices and the STATUS bit layout.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } cfg_state_e;

    // Register word index, taken from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_EMPTY    = 3;
    localparam int STAT_OVERFLOW = 4;

    function automatic logic [31:0] pack_status(
        input logic [15:0] remaining,
        input logic        overflow,
        input logic        empty,
        input logic        full,
        input logic        done,
        input logic        busy
    );
        logic [31:0] s;
        s                = 32'h0000_0000;
        s[31:16]         = remaining;
        s[STAT_OVERFLOW] = overflow;
        s[STAT_EMPTY]    = empty;
        s[STAT_FULL]     = full;
        s[STAT_DONE]     = done;
        s[STAT_BUSY]     = busy;
        return s;
    endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Word FIFO with synchronous reset and flush; a push while full succeeds
// only when a pop happens in the same cycle.
module cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign count     = wr_ptr_r - rd_ptr_r;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == {(AW + 1){1'b0}});
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone-programmed loader that streams buffered configuration words to the
// fabric with valid/ready handshaking and signals completion.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cfg_data_o,
    output logic        cfg_valid_o,
    input  logic        cfg_ready_i,
    output logic        cfg_done_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cfg_state_e  state_r, state_next_s;
    logic [15:0] len_r;
    logic [15:0] rem_r, rem_next_s;
    logic        ovf_r, ovf_next_s;
    logic        irq_r, irq_s;
    logic        ack_r;
    logic [31:0] dat_r;
    logic [31:0] rd_data_s;

    logic        hit_s, acc_s, wr_s;
    logic [1:0]  reg_idx_s;
    logic        start_s, abort_s, push_s, len_wr_s, pop_s;

    logic [31:0] fifo_head_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic        unused_s;

    assign hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // A held strobe is acked every other cycle, so each transfer is taken once
    assign acc_s     = hit_s & ~ack_r;
    assign wr_s      = acc_s & wbs_we_i & (wbs_sel_i == 4'hF);
    assign reg_idx_s = wbs_adr_i[3:2];
    assign start_s   = wr_s & (reg_idx_s == REG_CTRL) & wbs_dat_i[0];
    assign abort_s   = wr_s & (reg_idx_s == REG_CTRL) & wbs_dat_i[1];
    assign len_wr_s  = wr_s & (reg_idx_s == REG_LEN);
    assign push_s    = wr_s & (reg_idx_s == REG_DATA);

    assign cfg_valid_o = (state_r == ST_LOAD) & ~fifo_empty_s;
    assign cfg_data_o  = cfg_valid_o ? fifo_head_s : 32'h0000_0000;
    assign pop_s       = cfg_valid_o & cfg_ready_i;
    assign cfg_done_o  = (state_r == ST_DONE);
    assign irq_o       = irq_r;
    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign unused_s    = ^{wbs_adr_i[1:0], fifo_count_s};

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (abort_s),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wbs_dat_i),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Next-state, remaining-count and completion-pulse logic
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = rem_r;
        irq_s        = 1'b0;
        if (abort_s) begin
            state_next_s = ST_IDLE;
            rem_next_s   = 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        if (len_r != 16'h0000) begin
                            state_next_s = ST_LOAD;
                            rem_next_s   = len_r;
                        end else begin
                            state_next_s = ST_DONE;
                            irq_s        = 1'b1;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_LOAD: begin
                    if (pop_s) begin
                        if (rem_r > 16'h0001) begin
                            rem_next_s = rem_r - 16'h0001;
                        end else begin
                            rem_next_s   = 16'h0000;
                            state_next_s = ST_DONE;
                            irq_s        = 1'b1;
                        end
                    end else begin
                        rem_next_s = rem_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    rem_next_s   = 16'h0000;
                end
            endcase
        end
    end

    // Sticky overflow: set by a dropped DATA write, cleared by START/ABORT
    always_comb begin
        ovf_next_s = ovf_r;
        if (start_s || abort_s) begin
            ovf_next_s = 1'b0;
        end else if (push_s && fifo_full_s && !pop_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Register read mux
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (reg_idx_s)
            REG_LEN:    rd_data_s = {16'h0000, len_r};
            REG_STATUS: rd_data_s = pack_status(rem_r, ovf_r, fifo_empty_s, fifo_full_s,
                                                cfg_done_o, state_r == ST_LOAD);
            default:    rd_data_s = 32'h0000_0000;
        endcase
    end

    // Bus acknowledge and read data, aligned on the same edge
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= acc_s;
            dat_r <= (acc_s && !wbs_we_i) ? rd_data_s : 32'h0000_0000;
        end
    end

    // Control state registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            len_r   <= 16'h0000;
            rem_r   <= 16'h0000;
            ovf_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rem_r   <= rem_next_s;
            ovf_r   <= ovf_next_s;
            irq_r   <= irq_s;
            if (len_wr_s) begin
                len_r <= wbs_dat_i[15:0];
            end
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader: bus access, streaming,
// backpressure, overflow, abort, reset and edge cases.
module tb_fpga_cfg_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_LEN  = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] cfg_data;
    logic        cfg_valid, cfg_done, irq;
    logic        cfg_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int irq_cnt  = 0;
    logic [31:0] got_q [$];

    fpga_cfg_loader #(.BASE_ADR(BASE), .FIFO_DEPTH(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .cfg_data_o  (cfg_data),
        .cfg_valid_o (cfg_valid),
        .cfg_ready_i (cfg_ready),
        .cfg_done_o  (cfg_done),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // Record accepted fabric words and completion pulses mid-cycle
    always @(negedge clk) begin
        if (cfg_valid && cfg_ready) got_q.push_back(cfg_data);
        if (irq) irq_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; adr = a; wdat = d;
        do begin tick(); n++; end while (!ack && n < 8);
        check("wr_ack", 32'(ack), 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
        do begin tick(); n++; end while (!ack && n < 8);
        check("rd_ack", 32'(ack), 32'h1);
        d = rdat;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin tick(); n++; end
        check(tag, 32'(cfg_done), 32'h1);
    endtask

    initial begin
        logic [31:0] v;
        int base;
        int irq0;
        int acks;

        tick(); tick();
        rst = 1'b0;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_valid", 32'(cfg_valid), 32'h0);
        check("rst_data", cfg_data, 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        wb_read(A_STAT, v);
        check("rst_status", v, 32'h0000_0008);

        // Basic load
        base = got_q.size(); irq0 = irq_cnt;
        wb_write(A_LEN, 32'd3, 4'hF);
        wb_write(A_DATA, 32'hA1, 4'hF);
        wb_write(A_DATA, 32'hA2, 4'hF);
        wb_write(A_DATA, 32'hA3, 4'hF);
        cfg_ready = 1'b1;
        wb_write(A_CTRL, 32'h1, 4'hF);
        wait_done("basic_done", 20);
        tick();
        check("basic_cnt", got_q.size() - base, 32'd3);
        check("basic_w0", got_q[base], 32'hA1);
        check("basic_w1", got_q[base+1], 32'hA2);
        check("basic_w2", got_q[base+2], 32'hA3);
        check("basic_irq", irq_cnt - irq0, 32'd1);
        wb_read(A_STAT, v);
        check("basic_status", v, 32'h0000_000A);   // done plus FIFO empty

        // Backpressure
        cfg_ready = 1'b0;
        base = got_q.size(); irq0 = irq_cnt;
        wb_write(A_LEN, 32'd2, 4'hF);
        wb_write(A_DATA, 32'hB1, 4'hF);
        wb_write(A_DATA, 32'hB2, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(cfg_valid), 32'h1);
            check("bp_hold", cfg_data, 32'hB1);
        end
        wb_read(A_STAT, v);
        check("bp_status", v, 32'h0002_0001);
        cfg_ready = 1'b1;
        wait_done("bp_done", 20);
        tick();
        check("bp_cnt", got_q.size() - base, 32'd2);
        check("bp_w0", got_q[base], 32'hB1);
        check("bp_w1", got_q[base+1], 32'hB2);
        check("bp_irq", irq_cnt - irq0, 32'd1);

        // Overflow while preloading in DONE
        cfg_ready = 1'b0;
        base = got_q.size();
        for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'hC1 + 32'(i), 4'hF);
        wb_read(A_STAT, v);
        check("ovf_status", v, 32'h0000_0016);
        wb_write(A_LEN, 32'd4, 4'hF);
        cfg_ready = 1'b1;
        wb_write(A_CTRL, 32'h1, 4'hF);
        wait_done("ovf_done", 20);
        tick();
        check("ovf_cnt", got_q.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) check("ovf_word", got_q[base+i], 32'hC1 + 32'(i));
        wb_read(A_STAT, v);
        check("ovf_cleared", v, 32'h0000_000A);

        // Abort after two words
        cfg_ready = 1'b0;
        base = got_q.size();
        wb_write(A_LEN, 32'd4, 4'hF);
        for (int i = 0; i < 4; i++) wb_write(A_DATA, 32'hD1 + 32'(i), 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        cfg_ready = 1'b1;
        tick(); tick();
        cfg_ready = 1'b0;
        check("abt_cnt", got_q.size() - base, 32'd2);
        check("abt_w1", got_q[base+1], 32'hD2);
        irq0 = irq_cnt;
        wb_write(A_CTRL, 32'h2, 4'hF);
        check("abt_valid", 32'(cfg_valid), 32'h0);
        check("abt_done", 32'(cfg_done), 32'h0);
        wb_read(A_STAT, v);
        check("abt_status", v, 32'h0000_0008);
        tick(); tick();
        check("abt_irq", irq_cnt - irq0, 32'd0);

        // Reset in the middle of a load
        wb_write(A_LEN, 32'd2, 4'hF);
        wb_write(A_DATA, 32'hE1, 4'hF);
        wb_write(A_DATA, 32'hE2, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("mid_valid", 32'(cfg_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(cfg_valid), 32'h0);
        check("mrst_data", cfg_data, 32'h0);
        check("mrst_done", 32'(cfg_done), 32'h0);
        check("mrst_irq", 32'(irq), 32'h0);
        check("mrst_ack", 32'(ack), 32'h0);
        wb_read(A_STAT, v);
        check("mrst_status", v, 32'h0000_0008);
        wb_read(A_LEN, v);
        check("mrst_len", v, 32'h0);

        // START with LEN=0 completes immediately with a single pulse
        wb_write(A_CTRL, 32'h1, 4'hF);
        check("len0_done", 32'(cfg_done), 32'h1);
        check("len0_irq", 32'(irq), 32'h1);
        tick();
        check("len0_irq_end", 32'(irq), 32'h0);

        // Partial byte select is acked but ignored; upper LEN bits read 0
        wb_write(A_LEN, 32'hFFFF_0005, 4'hF);
        wb_write(A_LEN, 32'h0000_0077, 4'h3);
        wb_read(A_LEN, v);
        check("sel_len", v, 32'h0000_0005);
        wb_read(A_CTRL, v);
        check("ctrl_rd", v, 32'h0);

        // Out-of-window address never acks
        acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h10;
        for (int i = 0; i < 4; i++) begin tick(); if (ack) acks++; end
        cyc = 1'b0; stb = 1'b0;
        check("miss_ack", 32'(acks), 32'd0);

        // Held strobe: acks alternate, never back to back
        acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = A_LEN;
        for (int i = 0; i < 4; i++) begin tick(); if (ack) acks++; end
        cyc = 1'b0; stb = 1'b0;
        check("held_acks", 32'(acks), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
